dst_writer: RTL and testbench
=============================

Name: dst_writer

Overview:
- Downstream neighbour of the copy stage. Drains the 64-bit destination FIFO that the copy stage fills and writes each word to system memory as a Wishbone B3 master, using incrementing bursts.
- Started once per descriptor with a destination address.
- Reports completion, error, and the number of words written back to the descriptor controller.

Parameters:
- AW, 32, Wishbone address width (bytes).
- CW, 16, width of the written-word counter.

Ports:
- wb_clk_i  in  1  system clock; single clock domain.
- wb_rst_i  in  1  asynchronous, active-high reset.
- dst_start  in  1  one-cycle start pulse; ignored unless in S_IDLE, S_DONE or S_ERR.
- dst_addr  in  AW  destination byte address; bits [2:0] are ignored (64-bit aligned).
- m_dst_getn  out  1  active-low pop strobe to the destination FIFO.
- m_dst  in  64  FIFO head data, first-word-fall-through (valid while !m_dst_empty).
- m_dst_last  in  1  marks the head word as the descriptor's final word.
- m_dst_empty  in  1  FIFO empty.
- m_dst_almost_empty  in  1  FIFO holds at most one word.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  64  write data, equal to m_dst.
- wbm_sel_o  out  8  byte selects, constant 8'hff.
- wbm_we_o  out  1  constant 1 while wbm_cyc_o is high, else 0.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type extension, constant 2'b00 (linear).
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- dst_done  out  1  one-cycle pulse when the last word is acknowledged.
- dst_err  out  1  sticky error flag; cleared by dst_start.
- dst_wcnt  out  CW  words acknowledged since the last dst_start.

Behaviour:
- Reset values (asynchronous): state S_IDLE, wbm_cyc_o=0, wbm_stb_o=0, wbm_adr_o=0, wbm_cti_o=3'b000, dst_done=0, dst_err=0, dst_wcnt=0, m_dst_getn=1.
- States: S_IDLE, S_WAIT, S_WR, S_DONE, S_ERR; 3-bit state register.
- dst_start, accepted in S_IDLE, S_DONE or S_ERR:
  - latches adr = {dst_addr[AW-1:3], 3'b000};
  - clears dst_wcnt and dst_err;
  - moves to S_WAIT.
- S_WAIT:
  - wbm_cyc_o and wbm_stb_o are 0.
  - When !m_dst_empty, go to S_WR next cycle.
- S_WR:
  - wbm_cyc_o, wbm_stb_o and wbm_we_o are 1.
  - wbm_dat_o = m_dst (combinational from the FIFO head); wbm_adr_o = adr.
  - Outputs are held until ack or err.
- Pop rule: m_dst_getn = !(state==S_WR && wbm_ack_i), combinational, so there is exactly one pop per acknowledged beat.
- On ack in S_WR:
  - adr += 8, wrapping modulo 2^AW;
  - dst_wcnt += 1, saturating at all-ones.
  - Next state:
    - if m_dst_last, go to S_DONE;
    - else if m_dst_almost_empty, go to S_WAIT (the FIFO is empty after this pop);
    - else stay in S_WR, and the next beat follows with no idle cycle.
- CTI in S_WR:
  - 3'b010 when !m_dst_last && !m_dst_almost_empty;
  - otherwise 3'b111 (end of burst).
  - Every burst therefore terminates with 3'b111 before cyc drops.
- S_DONE:
  - dst_done is high for the first cycle only.
  - Stay in S_DONE until dst_start.
- On wbm_err_i in S_WR (err takes priority over a simultaneous ack):
  - no pop; adr and dst_wcnt are unchanged;
  - dst_err=1; go to S_ERR, which drops cyc/stb.
  - S_ERR holds until dst_start. The FIFO is not drained; flushing is the controller's job.
- An ack or err outside S_WR is ignored.
- A dst_start outside the accepting states (S_IDLE, S_DONE, S_ERR) is ignored.
- Reset mid-burst drops cyc/stb immediately and asynchronously. Any partially written data is lost; the FIFO is reset by the same wb_rst_i.
- Latency: the first stb is asserted 2 cycles after dst_start if the FIFO is already non-empty. The sustained rate is 1 word per cycle under zero-wait-state ack.

Decomposition:
- Shared package ss_dma_pkg holds:
  - state encodings;
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - BTE_LINEAR.
- No sub-module is needed. The block is a single FSM plus an address register and a counter (about 150 lines).

Test Plan:
- Ack rate and FIFO contents:
  - FIFO preloaded with 4 words 0x11..0x44, last on word 4.
  - dst_addr=0x1000, ack every cycle.
  - Expected: addresses 0x1000/0x1008/0x1010/0x1018; cti 010,010,010,111; one dst_done pulse; dst_wcnt=4; 4 pops.
- FIFO underrun mid-transfer:
  - 2 words, then an empty gap of 5 cycles, then 1 word with last.
  - Expected: burst 1 ends with cti=111 on word 2 (almost_empty); cyc drops for the gap; word 3 goes to 0x1010 with cti=111; dst_wcnt=3.
- Wait states:
  - Ack delayed 3 cycles per beat.
  - Expected: adr and dat stable while stb is high; m_dst_getn low only in ack cycles.
- Bus error:
  - err asserted on beat 2 of a 4-word transfer.
  - Expected: dst_err=1, dst_wcnt=1, cyc=0, only 1 pop, no dst_done.
  - Then a new dst_start clears dst_err and dst_wcnt.
- Address wrap, unaligned start and reset:
  - dst_addr=0xFFFF_FFFB with 2 words: beats go to 0xFFFF_FFF8 then 0x0000_0000.
  - wb_rst_i asserted mid-burst: cyc/stb/done go to 0 in the same cycle, and the state returns to S_IDLE.

Source files
------------

// File: rtl/ss_dma_pkg.sv
// Shared definitions for the DMA streaming stages: FSM encodings and
// Wishbone B3 cycle-type / burst-type constants.
package ss_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_WR   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } dst_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [7:0] SEL_ALL     = 8'hff;

endpackage

// File: rtl/dst_writer.sv
// Destination writer: drains the 64-bit destination FIFO into system memory
// as a Wishbone B3 master using linear incrementing bursts.
module dst_writer
    import ss_dma_pkg::*;
#(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          dst_start,
    input  logic [AW-1:0] dst_addr,
    output logic          m_dst_getn,
    input  logic [63:0]   m_dst,
    input  logic          m_dst_last,
    input  logic          m_dst_empty,
    input  logic          m_dst_almost_empty,
    output logic [AW-1:0] wbm_adr_o,
    output logic [63:0]   wbm_dat_o,
    output logic [7:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          dst_done,
    output logic          dst_err,
    output logic [CW-1:0] dst_wcnt
);

    dst_state_e    state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          wr_s;
    logic          addr_lo_unused_s;

    // The low address bits are dropped: every beat is a full 64-bit word.
    assign addr_lo_unused_s = ^dst_addr[2:0];

    assign wr_s = (state_q == S_WR);

    // Next-state, address and counter update.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (dst_start) begin
                    state_d = S_WAIT;
                    adr_d   = {dst_addr[AW-1:3], 3'b000};
                    wcnt_d  = {CW{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                if (!m_dst_empty) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WR: begin
                // An error wins over a simultaneous ack and leaves the beat unconsumed.
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (wbm_ack_i) begin
                    adr_d = adr_q + {{(AW-4){1'b0}}, 4'h8};
                    if (wcnt_q != {CW{1'b1}}) begin
                        wcnt_d = wcnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        wcnt_d = wcnt_q;
                    end
                    if (m_dst_last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (m_dst_almost_empty) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, address, counter and status registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= {AW{1'b0}};
            wcnt_q  <= {CW{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Bus controls decode straight from the state flop, so reset drops them at once.
    assign wbm_cyc_o  = wr_s;
    assign wbm_stb_o  = wr_s;
    assign wbm_we_o   = wr_s;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = m_dst;
    assign wbm_sel_o  = SEL_ALL;
    assign wbm_bte_o  = BTE_LINEAR;
    assign wbm_cti_o  = !wr_s ? CTI_CLASSIC :
                        (!m_dst_last && !m_dst_almost_empty) ? CTI_INCR : CTI_EOB;
    assign m_dst_getn = !(wr_s && wbm_ack_i && !wbm_err_i);

    assign dst_done = done_q;
    assign dst_err  = err_q;
    assign dst_wcnt = wcnt_q;

endmodule

// File: tb/tb_dst_writer.sv
// Directed bench for dst_writer: behavioural FWFT FIFO, Wishbone slave with
// configurable wait states / error injection, and hand-computed expectations.
module tb_dst_writer;
    import ss_dma_pkg::*;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        dst_start = 1'b0;
    logic [31:0] dst_addr = 32'h0;
    logic        m_dst_getn;
    logic [63:0] m_dst = 64'h0;
    logic        m_dst_last = 1'b0;
    logic        m_dst_empty = 1'b1;
    logic        m_dst_almost_empty = 1'b1;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_o;
    logic [7:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        dst_done, dst_err;
    logic [15:0] dst_wcnt;

    dst_writer #(.AW(32), .CW(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .dst_start(dst_start), .dst_addr(dst_addr),
        .m_dst_getn(m_dst_getn), .m_dst(m_dst), .m_dst_last(m_dst_last),
        .m_dst_empty(m_dst_empty), .m_dst_almost_empty(m_dst_almost_empty),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .dst_done(dst_done), .dst_err(dst_err), .dst_wcnt(dst_wcnt)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: {last, data}; pushes queued by the stimulus, pops counted at the clock edge.
    logic [64:0] fifo[$];
    logic [64:0] push_q[$];
    int push_rd = 0;
    int pop_cnt = 0;
    int popped = 0;
    int flush_gen = 0;
    int flush_seen = 0;

    // Count one pop per rising edge with the pop strobe low.
    always @(posedge clk) begin
        if (!m_dst_getn) pop_cnt <= pop_cnt + 1;
    end

    // Apply pops, flushes and pushes away from the active edge, then present the head.
    always @(negedge clk) begin
        if (wb_rst_i || flush_gen != flush_seen) begin
            fifo.delete();
            popped = pop_cnt;
            flush_seen = flush_gen;
        end else begin
            while (popped < pop_cnt) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                popped++;
            end
        end
        while (push_rd < push_q.size()) begin
            fifo.push_back(push_q[push_rd]);
            push_rd++;
        end
        if (fifo.size() > 0) begin
            m_dst      = fifo[0][63:0];
            m_dst_last = fifo[0][64];
        end else begin
            m_dst      = 64'h0;
            m_dst_last = 1'b0;
        end
        m_dst_empty        = (fifo.size() == 0);
        m_dst_almost_empty = (fifo.size() <= 1);
    end

    // Wishbone slave: wait states, error injection, beat log, stability and pop checks.
    int ack_delay = 0;
    int err_at = -1;
    int beats = 0;
    int wait_cnt = 0;
    logic held = 1'b0;
    logic [31:0] prev_adr = 32'h0;
    logic [63:0] prev_dat = 64'h0;
    int viol = 0;
    int getn_viol = 0;
    logic [31:0] log_adr[$];
    logic [63:0] log_dat[$];
    logic [2:0]  log_cti[$];

    always @(negedge clk) begin
        #1;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_stb_o && !wb_rst_i) begin
            if (held && (wbm_adr_o != prev_adr || wbm_dat_o != prev_dat)) viol++;
            prev_adr = wbm_adr_o;
            prev_dat = wbm_dat_o;
            if (wait_cnt >= ack_delay) begin
                beats++;
                wait_cnt = 0;
                held = 1'b0;
                if (beats == err_at) begin
                    wbm_err_i = 1'b1;
                end else begin
                    wbm_ack_i = 1'b1;
                    log_adr.push_back(wbm_adr_o);
                    log_dat.push_back(wbm_dat_o);
                    log_cti.push_back(wbm_cti_o);
                end
            end else begin
                wait_cnt++;
                held = 1'b1;
            end
        end else begin
            wait_cnt = 0;
            held = 1'b0;
        end
        #1;
        if (m_dst_getn !== !(wbm_stb_o && wbm_ack_i && !wbm_err_i)) getn_viol++;
    end

    int done_cnt = 0;
    // Count done pulses.
    always @(negedge clk) begin
        if (dst_done) done_cnt++;
    end

    task automatic push_word(input logic last, input logic [63:0] d);
        push_q.push_back({last, d});
    endtask

    task automatic start(input logic [31:0] a);
        dst_addr = a;
        dst_start = 1'b1;
        @(negedge clk);
        dst_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!dst_done && !dst_err && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_in_time"}, 64'(n < budget), 64'h1);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (log_adr.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_in_time"}, 64'(n < budget), 64'h1);
    endtask

    int b, p0, d0, v0, g0, cyc_hi;
    logic [2:0] exp_cti;

    initial begin
        // Reset state
        #1;
        check_val("rst_cyc", wbm_cyc_o, 64'h0);
        check_val("rst_stb", wbm_stb_o, 64'h0);
        check_val("rst_we", wbm_we_o, 64'h0);
        check_val("rst_adr", wbm_adr_o, 64'h0);
        check_val("rst_cti", wbm_cti_o, 64'h0);
        check_val("rst_done", dst_done, 64'h0);
        check_val("rst_err", dst_err, 64'h0);
        check_val("rst_wcnt", dst_wcnt, 64'h0);
        check_val("rst_getn", m_dst_getn, 64'h1);
        check_val("rst_sel", wbm_sel_o, 64'hff);
        check_val("rst_bte", wbm_bte_o, 64'h0);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);

        // Test 1: four-word burst, zero-wait acks
        b = log_adr.size(); p0 = pop_cnt; d0 = done_cnt;
        push_word(1'b0, 64'h11); push_word(1'b0, 64'h22);
        push_word(1'b0, 64'h33); push_word(1'b1, 64'h44);
        @(negedge clk);
        @(negedge clk);
        start(32'h1000);
        check_val("t1_stb_wait", wbm_stb_o, 64'h0);
        @(negedge clk);
        check_val("t1_stb_first", wbm_stb_o, 64'h1);
        wait_end("t1", 30);
        repeat (3) @(negedge clk);
        check_val("t1_beats", log_adr.size() - b, 64'd4);
        for (int i = 0; i < 4; i++) begin
            exp_cti = (i == 3) ? CTI_EOB : CTI_INCR;
            check_val($sformatf("t1_adr%0d", i), log_adr[b+i], 64'h1000 + 64'(8*i));
            check_val($sformatf("t1_dat%0d", i), log_dat[b+i], 64'(17*(i+1)));
            check_val($sformatf("t1_cti%0d", i), log_cti[b+i], exp_cti);
        end
        check_val("t1_done_pulses", done_cnt - d0, 64'd1);
        check_val("t1_wcnt", dst_wcnt, 64'd4);
        check_val("t1_pops", pop_cnt - p0, 64'd4);
        check_val("t1_cyc_after", wbm_cyc_o, 64'h0);

        // Test 2: underrun gap between bursts
        b = log_adr.size(); d0 = done_cnt;
        push_word(1'b0, 64'h100); push_word(1'b0, 64'h200);
        @(negedge clk);
        @(negedge clk);
        start(32'h1000);
        wait_beats("t2_burst1", b + 2, 20);
        cyc_hi = 0;
        repeat (5) begin
            @(negedge clk);
            cyc_hi += int'(wbm_cyc_o);
        end
        check_val("t2_gap_cyc", cyc_hi, 64'd0);
        push_word(1'b1, 64'h300);
        wait_end("t2", 20);
        repeat (2) @(negedge clk);
        check_val("t2_adr0", log_adr[b], 64'h1000);
        check_val("t2_adr1", log_adr[b+1], 64'h1008);
        check_val("t2_adr2", log_adr[b+2], 64'h1010);
        check_val("t2_cti0", log_cti[b], CTI_INCR);
        check_val("t2_cti1", log_cti[b+1], CTI_EOB);
        check_val("t2_cti2", log_cti[b+2], CTI_EOB);
        check_val("t2_dat2", log_dat[b+2], 64'h300);
        check_val("t2_wcnt", dst_wcnt, 64'd3);
        check_val("t2_done_pulses", done_cnt - d0, 64'd1);

        // Test 3: three wait states per beat
        ack_delay = 3;
        b = log_adr.size(); p0 = pop_cnt; v0 = viol; g0 = getn_viol;
        push_word(1'b0, 64'hAAAA_0000_0000_0001);
        push_word(1'b0, 64'hBBBB_0000_0000_0002);
        push_word(1'b1, 64'hCCCC_0000_0000_0003);
        @(negedge clk);
        @(negedge clk);
        start(32'h2000);
        wait_end("t3", 60);
        repeat (2) @(negedge clk);
        check_val("t3_stable", viol - v0, 64'd0);
        check_val("t3_getn", getn_viol - g0, 64'd0);
        check_val("t3_pops", pop_cnt - p0, 64'd3);
        check_val("t3_wcnt", dst_wcnt, 64'd3);
        check_val("t3_adr2", log_adr[b+2], 64'h2010);
        check_val("t3_dat1", log_dat[b+1], 64'hBBBB_0000_0000_0002);
        ack_delay = 0;

        // Test 4: bus error on beat 2, then restart clears status
        b = log_adr.size(); p0 = pop_cnt; d0 = done_cnt;
        push_word(1'b0, 64'h1); push_word(1'b0, 64'h2);
        push_word(1'b0, 64'h3); push_word(1'b1, 64'h4);
        @(negedge clk);
        err_at = beats + 2;
        @(negedge clk);
        start(32'h3000);
        wait_end("t4", 30);
        check_val("t4_err", dst_err, 64'h1);
        check_val("t4_wcnt", dst_wcnt, 64'd1);
        check_val("t4_cyc", wbm_cyc_o, 64'h0);
        repeat (3) @(negedge clk);
        check_val("t4_cyc_hold", wbm_cyc_o, 64'h0);
        check_val("t4_pops", pop_cnt - p0, 64'd1);
        check_val("t4_no_done", done_cnt - d0, 64'd0);
        check_val("t4_beats", log_adr.size() - b, 64'd1);
        err_at = -1;
        flush_gen++;
        @(negedge clk);
        @(negedge clk);
        start(32'h4000);
        check_val("t4_err_clr", dst_err, 64'h0);
        check_val("t4_wcnt_clr", dst_wcnt, 64'd0);
        b = log_adr.size();
        push_word(1'b1, 64'h77);
        wait_end("t4b", 20);
        check_val("t4b_wcnt", dst_wcnt, 64'd1);
        check_val("t4b_adr", log_adr[b], 64'h4000);

        // Test 5: unaligned start wrapping past the top of memory
        b = log_adr.size();
        push_word(1'b0, 64'h5A); push_word(1'b1, 64'h5B);
        @(negedge clk);
        @(negedge clk);
        start(32'hFFFF_FFFB);
        wait_end("t5", 20);
        check_val("t5_adr0", log_adr[b], 64'hFFFF_FFF8);
        check_val("t5_adr1", log_adr[b+1], 64'h0000_0000);
        check_val("t5_wcnt", dst_wcnt, 64'd2);

        // Test 6: asynchronous reset mid-burst
        ack_delay = 2;
        b = log_adr.size();
        push_word(1'b0, 64'h61); push_word(1'b0, 64'h62);
        push_word(1'b0, 64'h63); push_word(1'b1, 64'h64);
        @(negedge clk);
        @(negedge clk);
        start(32'h5000);
        wait_beats("t6_beat1", b + 1, 30);
        check_val("t6_stb_before", wbm_stb_o, 64'h1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_val("t6_cyc_rst", wbm_cyc_o, 64'h0);
        check_val("t6_stb_rst", wbm_stb_o, 64'h0);
        check_val("t6_done_rst", dst_done, 64'h0);
        check_val("t6_wcnt_rst", dst_wcnt, 64'h0);
        check_val("t6_adr_rst", wbm_adr_o, 64'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        wb_rst_i = 1'b0;
        ack_delay = 0;
        push_word(1'b1, 64'h99);
        cyc_hi = 0;
        repeat (5) begin
            @(negedge clk);
            cyc_hi += int'(wbm_cyc_o);
        end
        check_val("t6_idle_after_rst", cyc_hi, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
